// File: rtl/regfile_param_scrub_pkg.sv
// Shared types and helpers for the parametrised register file.
// Holds the clear-engine state encoding and the address-width function.
package regfile_pkg;

    typedef enum logic {
        RF_IDLE  = 1'b0,
        RF_CLEAR = 1'b1
    } rf_state_t;

    // Address width for a given depth, never narrower than one bit.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/regfile_param_scrub_if.sv
// Write/read/clear bundle of the register file; slave = file side, master = requester.
// Widths follow WIDTH and DEPTH so both ends agree on address size.
interface regfile_param_scrub_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
);
    localparam int ADDR_W = regfile_pkg::clog2(DEPTH);

    logic              clr_req;
    logic              busy;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WIDTH-1:0]  wr_data;
    logic              wr_ack;
    logic              rd_en_a;
    logic [ADDR_W-1:0] rd_addr_a;
    logic [WIDTH-1:0]  rd_data_a;
    logic              rd_valid_a;
    logic              rd_en_b;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [WIDTH-1:0]  rd_data_b;
    logic              rd_valid_b;
    logic              addr_err;

    modport slave (
        input  clr_req, wr_en, wr_addr, wr_data,
        input  rd_en_a, rd_addr_a, rd_en_b, rd_addr_b,
        output busy, wr_ack, rd_data_a, rd_valid_a, rd_data_b, rd_valid_b, addr_err
    );

    modport master (
        output clr_req, wr_en, wr_addr, wr_data,
        output rd_en_a, rd_addr_a, rd_en_b, rd_addr_b,
        input  busy, wr_ack, rd_data_a, rd_valid_a, rd_data_b, rd_valid_b, addr_err
    );

endinterface

// File: rtl/regfile_param_scrub_rd_port.sv
// One registered read port: range check, hardwired zero, write bypass, valid flop.
// One-cycle latency; requests while busy are dropped and the data register holds.
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 8,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1,
    localparam int ADDR_W  = clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              busy_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    input  logic [WIDTH-1:0]  ent_data_i,
    input  logic              wr_ack_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [WIDTH-1:0]  wr_data_i,
    output logic [WIDTH-1:0]  rd_data_o,
    output logic              rd_valid_o,
    output logic              err_o
);
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    logic             in_range;
    logic             take;
    logic [WIDTH-1:0] sel_data;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;

    assign in_range = ({1'b0, rd_addr_i} < DEPTH_C);
    assign take     = rd_en_i & ~busy_i;
    assign err_o    = take & ~in_range;

    always_comb begin
        sel_data = ent_data_i;
        if (!in_range) begin
            sel_data = '0;
        end else if ((ZERO_REG != 0) && (rd_addr_i == '0)) begin
            sel_data = '0;
        end else if ((BYPASS != 0) && wr_ack_i && (wr_addr_i == rd_addr_i)) begin
            sel_data = wr_data_i;
        end
    end

    always_comb begin
        rd_valid_d = take;
        rd_data_d  = take ? sel_data : rd_data_q;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;

endmodule

// File: rtl/regfile_param_scrub.sv
// 2R/1W register file with a one-entry-per-cycle clear engine after reset or clr_req.
// Reads register in one cycle; all traffic is refused while the clear engine is busy.
module regfile_param_scrub
    import regfile_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 8,
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input logic                  clk,
    input logic                  reset,
    regfile_param_scrub_if.slave rf
);
    localparam int              ADDR_W   = clog2(DEPTH);
    localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    rf_state_t         state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              clr_we;
    logic              busy;
    logic              addr_err_q, addr_err_d;
    logic [WIDTH-1:0]  mem_q [DEPTH];

    logic              wr_in_range;
    logic              wr_ack;
    logic              wr_we;
    logic [WIDTH-1:0]  ent_a, ent_b;
    logic              err_a, err_b;

    assign busy        = (state_q == RF_CLEAR);
    assign wr_in_range = ({1'b0, rf.wr_addr} < DEPTH_C);
    assign wr_ack      = rf.wr_en & ~busy & wr_in_range;
    // Entry 0 acks writes but never stores them when hardwired to zero.
    assign wr_we       = wr_ack & ~((ZERO_REG != 0) && (rf.wr_addr == '0));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        clr_we  = 1'b0;
        case (state_q)
            RF_IDLE: begin
                if (rf.clr_req) begin
                    state_d = RF_CLEAR;
                    idx_d   = '0;
                end
            end
            RF_CLEAR: begin
                clr_we = 1'b1;
                if (rf.clr_req) begin
                    idx_d = '0;
                end else if (idx_q == LAST_IDX) begin
                    state_d = RF_IDLE;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + ADDR_W'(1);
                end
            end
            default: begin
                state_d = RF_CLEAR;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RF_CLEAR;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Storage is not reset directly; the clear engine zeroes it after reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (clr_we) begin
                mem_q[idx_q] <= '0;
            end else if (wr_we) begin
                mem_q[rf.wr_addr] <= rf.wr_data;
            end
        end
    end

    always_comb begin
        addr_err_d = addr_err_q;
        if (rf.clr_req) begin
            addr_err_d = 1'b0;
        end else if (err_a | err_b | (rf.wr_en & ~busy & ~wr_in_range)) begin
            addr_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_err_q <= 1'b0;
        end else begin
            addr_err_q <= addr_err_d;
        end
    end

    assign ent_a = ({1'b0, rf.rd_addr_a} < DEPTH_C) ? mem_q[rf.rd_addr_a] : '0;
    assign ent_b = ({1'b0, rf.rd_addr_b} < DEPTH_C) ? mem_q[rf.rd_addr_b] : '0;

    regfile_rd_port #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS)
    ) u_rd_a (
        .clk_i      (clk),
        .reset_i    (reset),
        .busy_i     (busy),
        .rd_en_i    (rf.rd_en_a),
        .rd_addr_i  (rf.rd_addr_a),
        .ent_data_i (ent_a),
        .wr_ack_i   (wr_ack),
        .wr_addr_i  (rf.wr_addr),
        .wr_data_i  (rf.wr_data),
        .rd_data_o  (rf.rd_data_a),
        .rd_valid_o (rf.rd_valid_a),
        .err_o      (err_a)
    );

    regfile_rd_port #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS)
    ) u_rd_b (
        .clk_i      (clk),
        .reset_i    (reset),
        .busy_i     (busy),
        .rd_en_i    (rf.rd_en_b),
        .rd_addr_i  (rf.rd_addr_b),
        .ent_data_i (ent_b),
        .wr_ack_i   (wr_ack),
        .wr_addr_i  (rf.wr_addr),
        .wr_data_i  (rf.wr_data),
        .rd_data_o  (rf.rd_data_b),
        .rd_valid_o (rf.rd_valid_b),
        .err_o      (err_b)
    );

    assign rf.busy     = busy;
    assign rf.wr_ack   = wr_ack;
    assign rf.addr_err = addr_err_q;

endmodule

// File: tb/tb_regfile_param_scrub.sv
// Drives two configurations (8-deep bypassing, 12-deep zero-reg non-bypassing) with
// identical stimulus and compares both against a behavioural model of the file.
module tb_regfile_param_scrub;

    logic clk;
    logic reset;
    logic clr, we, ea, eb;
    logic [3:0]  wa, aa, ab;
    logic [15:0] wd;

    regfile_param_scrub_if #(.WIDTH(16), .DEPTH(8))  if0 ();
    regfile_param_scrub_if #(.WIDTH(16), .DEPTH(12)) if1 ();

    assign if0.clr_req   = clr;
    assign if0.wr_en     = we;
    assign if0.wr_addr   = wa[2:0];
    assign if0.wr_data   = wd;
    assign if0.rd_en_a   = ea;
    assign if0.rd_addr_a = aa[2:0];
    assign if0.rd_en_b   = eb;
    assign if0.rd_addr_b = ab[2:0];

    assign if1.clr_req   = clr;
    assign if1.wr_en     = we;
    assign if1.wr_addr   = wa;
    assign if1.wr_data   = wd;
    assign if1.rd_en_a   = ea;
    assign if1.rd_addr_a = aa;
    assign if1.rd_en_b   = eb;
    assign if1.rd_addr_b = ab;

    regfile_param_scrub #(.WIDTH(16), .DEPTH(8), .ZERO_REG(0), .BYPASS(1)) u_dut0 (
        .clk   (clk),
        .reset (reset),
        .rf    (if0)
    );

    regfile_param_scrub #(.WIDTH(16), .DEPTH(12), .ZERO_REG(1), .BYPASS(0)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .rf    (if1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model of each configuration: depth, zero-reg, bypass, address mask.
    int          cfg_d  [2] = '{8, 12};
    int          cfg_z  [2] = '{0, 1};
    int          cfg_bp [2] = '{1, 0};
    int          cfg_m  [2] = '{7, 15};
    int          clear_left [2];
    bit          m_err [2];
    bit          m_rdv [2][2];
    logic [15:0] m_rdd [2][2];
    logic [15:0] m_mem [2][16];

    int n_cmp;
    int n_bad;

    task automatic chk(input string tag, input int k, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL d%0d %s observed=%h required=%h", k, tag, obs, exp);
        end
    endtask

    task automatic model_edge(input int k, input bit r, input bit c, input bit w_en, input int w_a,
                              input logic [15:0] w_d, input bit en0, input int ad0,
                              input bit en1, input int ad1);
        bit busy, ack;
        bit en [2];
        int ad [2];
        int dep;
        dep = cfg_d[k];
        en[0] = en0; ad[0] = ad0 & cfg_m[k];
        en[1] = en1; ad[1] = ad1 & cfg_m[k];
        w_a = w_a & cfg_m[k];
        if (r) begin
            clear_left[k] = dep;
            m_err[k] = 1'b0;
            for (int p = 0; p < 2; p++) begin
                m_rdv[k][p] = 1'b0;
                m_rdd[k][p] = 16'h0000;
            end
        end else begin
            busy = (clear_left[k] != 0);
            ack  = w_en && !busy && (w_a < dep);
            for (int p = 0; p < 2; p++) begin
                if (en[p] && !busy) begin
                    m_rdv[k][p] = 1'b1;
                    if (ad[p] >= dep)                          m_rdd[k][p] = 16'h0000;
                    else if (cfg_z[k] != 0 && ad[p] == 0)      m_rdd[k][p] = 16'h0000;
                    else if (cfg_bp[k] != 0 && ack && w_a == ad[p]) m_rdd[k][p] = w_d;
                    else                                       m_rdd[k][p] = m_mem[k][ad[p]];
                end else begin
                    m_rdv[k][p] = 1'b0;
                end
            end
            if (c) m_err[k] = 1'b0;
            else if (!busy && ((w_en && w_a >= dep) || (en[0] && ad[0] >= dep) || (en[1] && ad[1] >= dep)))
                m_err[k] = 1'b1;
            if (ack && !(cfg_z[k] != 0 && w_a == 0)) m_mem[k][w_a] = w_d;
            if (busy) m_mem[k][dep - clear_left[k]] = 16'h0000;
            if (c) clear_left[k] = dep;
            else if (busy) clear_left[k]--;
        end
    endtask

    task automatic cyc(input bit r, input bit c, input bit w_en, input int w_a, input logic [15:0] w_d,
                       input bit en0, input int ad0, input bit en1, input int ad1);
        bit exp_ack;
        int wm;
        @(negedge clk);
        reset = r; clr = c; we = w_en; wa = 4'(w_a); wd = w_d;
        ea = en0; aa = 4'(ad0); eb = en1; ab = 4'(ad1);
        #1;
        for (int k = 0; k < 2; k++) begin
            wm = w_a & cfg_m[k];
            exp_ack = w_en && (clear_left[k] == 0) && (wm < cfg_d[k]);
            chk("wr_ack", k, {15'd0, (k == 0) ? if0.wr_ack : if1.wr_ack}, {15'd0, exp_ack});
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) model_edge(k, r, c, w_en, w_a, w_d, en0, ad0, en1, ad1);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("busy", k, {15'd0, (k == 0) ? if0.busy : if1.busy}, {15'd0, clear_left[k] != 0});
            chk("addr_err", k, {15'd0, (k == 0) ? if0.addr_err : if1.addr_err}, {15'd0, m_err[k]});
            chk("rd_valid_a", k, {15'd0, (k == 0) ? if0.rd_valid_a : if1.rd_valid_a}, {15'd0, m_rdv[k][0]});
            chk("rd_valid_b", k, {15'd0, (k == 0) ? if0.rd_valid_b : if1.rd_valid_b}, {15'd0, m_rdv[k][1]});
            chk("rd_data_a", k, (k == 0) ? if0.rd_data_a : if1.rd_data_a, m_rdd[k][0]);
            chk("rd_data_b", k, (k == 0) ? if0.rd_data_b : if1.rd_data_b, m_rdd[k][1]);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 16'h0, 0, 0, 0, 0);
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        reset = 1'b1; clr = 1'b0; we = 1'b0; wa = '0; wd = '0;
        ea = 1'b0; aa = '0; eb = 1'b0; ab = '0;
        for (int k = 0; k < 2; k++) begin
            clear_left[k] = cfg_d[k];
            m_err[k] = 1'b0;
            for (int p = 0; p < 2; p++) begin
                m_rdv[k][p] = 1'b0;
                m_rdd[k][p] = 16'h0;
            end
            for (int a = 0; a < 16; a++) m_mem[k][a] = 16'h0;
        end

        // Reset, then the power-up clear sequence; read after it completes.
        repeat (3) cyc(1, 0, 0, 0, 16'h0, 1, 1, 1, 2);
        idle(13);
        cyc(0, 0, 0, 0, 16'h0, 1, 2, 1, 6);
        idle(1);

        // Write then dual read of the same entry.
        cyc(0, 0, 1, 3, 16'hBEEF, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 16'h0, 1, 3, 1, 3);
        idle(1);

        // Same-cycle write and read: bypass versus old contents.
        cyc(0, 0, 1, 5, 16'h00AA, 0, 0, 0, 0);
        cyc(0, 0, 1, 5, 16'h1234, 1, 5, 1, 5);
        cyc(0, 0, 0, 0, 16'h0, 1, 5, 0, 0);

        // Entry 0 write: stored in the plain file, discarded by the zero-reg file.
        cyc(0, 0, 1, 0, 16'hFFFF, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 16'h0, 1, 0, 1, 0);

        // Out-of-range write/read, then clr_req clears the sticky flag.
        cyc(0, 0, 1, 13, 16'h5555, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 16'h0, 1, 14, 1, 11);
        idle(2);
        cyc(0, 1, 0, 0, 16'h0, 0, 0, 0, 0);
        idle(13);

        // Fill with A5A5, clear with a write attempt mid-clear, read back everything.
        for (int a = 0; a < 12; a++) cyc(0, 0, 1, a, 16'hA5A5, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 16'h0, 0, 0, 0, 0);
        idle(1);
        cyc(0, 0, 1, 2, 16'h7777, 1, 2, 0, 0);
        idle(12);
        for (int a = 0; a < 12; a++) cyc(0, 0, 0, 0, 16'h0, 1, a, 1, 11 - a);
        idle(1);

        // Reset part-way through a clear restarts the full count.
        cyc(0, 1, 0, 0, 16'h0, 0, 0, 0, 0);
        idle(3);
        repeat (2) cyc(1, 0, 0, 0, 16'h0, 0, 0, 0, 0);
        idle(13);

        // Random traffic with occasional clears and resets.
        for (int i = 0; i < 3000; i++) begin
            bit r, c, w;
            r = ($urandom_range(0, 249) == 0);
            c = ($urandom_range(0, 59) == 0);
            w = r ? 1'b0 : ($urandom_range(0, 1) == 1);
            cyc(r, c, w, int'($urandom_range(0, 15)), 16'($urandom),
                ($urandom_range(0, 1) == 1), int'($urandom_range(0, 15)),
                ($urandom_range(0, 1) == 1), int'($urandom_range(0, 15)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/regfile_param_scrub.md
Name: regfile_param_scrub

Overview:
Parametrised 2-read/1-write register file for the processor datapath. Generalises the fixed 4x16 and 8x16 files in width and depth, and adds:
- registered reads with valid strobes
- optional write-to-read bypass
- optional hardwired-zero entry 0
- out-of-range address detection
- a sequential clear engine that zeroes one entry per cycle after reset or on request.

Parameters:
WIDTH, 16, data width in bits (>=1)
DEPTH, 8, number of entries (>=2, need not be a power of two)
ZERO_REG, 0, 1 = entry 0 always reads 0; writes to it are acked and discarded
BYPASS, 1, 1 = same-cycle write data is forwarded to a matching read; 0 = read returns the old contents
(localparam ADDR_W = clog2(DEPTH), minimum 1)

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high
clr_req  input  1  pulse: start clearing all entries
busy  output  1  high while the clear engine runs
wr_en  input  1  write request
wr_addr  input  ADDR_W  write address
wr_data  input  WIDTH  write data
wr_ack  output  1  combinational: write accepted this cycle
rd_en_a  input  1  read request, port A
rd_addr_a  input  ADDR_W  read address, port A
rd_data_a  output  WIDTH  registered read data, port A
rd_valid_a  output  1  registered: rd_data_a valid
rd_en_b / rd_addr_b / rd_data_b / rd_valid_b  same as port A, for port B
addr_err  output  1  sticky out-of-range flag

Behaviour:
- Clock and reset: clock is clk; reset is reset, synchronous, active-high.
- State machine has two states, RF_IDLE and RF_CLEAR.
- Reset:
  - While reset is high: state=RF_CLEAR, clear index=0.
  - Outputs during reset: busy=1, rd_data_a/b=0, rd_valid_a/b=0, addr_err=0.
- Clear sequence:
  - Edges 1..DEPTH after reset release write 0 to entries 0..DEPTH-1 in order.
  - The edge that clears entry DEPTH-1 moves the state to RF_IDLE.
  - busy is registered as (state==RF_CLEAR), so it is high for exactly DEPTH cycles after release.
- clr_req:
  - In RF_IDLE: next state RF_CLEAR with index 0, same sequence as above.
  - In RF_CLEAR: restarts the index at 0.
  - clr_req also clears addr_err on the same edge.
- While busy=1:
  - wr_ack=0 and writes are dropped.
  - Reads are dropped; rd_valid stays 0 and rd_data holds its value.
- Write acceptance: wr_ack = wr_en & !busy & (wr_addr < DEPTH).
  - An acked write updates the entry on the same edge.
  - With ZERO_REG=1 and wr_addr=0 the write is acked but the entry is unchanged.
- Read, 1-cycle latency: if rd_en_x & !busy, then on the next edge rd_valid_x=1 and rd_data_x takes the value below; otherwise rd_valid_x=0 and rd_data_x holds.
  - rd_data_x selection, in priority order:
    1. addr >= DEPTH -> 0
    2. ZERO_REG=1 and addr=0 -> 0
    3. BYPASS=1 and wr_ack and wr_addr==rd_addr_x -> wr_data
    4. otherwise -> entry contents before the edge
- Both ports may read the same address in the same cycle; each independently gives the result above.
- addr_err: set on the edge after any rd_en_x or wr_en with an address >= DEPTH while !busy. Cleared only by reset or clr_req; if set and clear occur together, clear wins.
- Simultaneous events in RF_IDLE:
  - A write in the same cycle as clr_req is accepted.
  - That entry is then zeroed by the sequence.
- Reset mid-clear restarts the sequence from index 0.

Decomposition:
- Package regfile_pkg holds:
  - state enum rf_state_t {RF_IDLE, RF_CLEAR}
  - a clog2 function used for ADDR_W
- Sub-module regfile_rd_port holds the registered read path: range check, zero-reg, bypass mux, valid flop.
  - Parameters: WIDTH, DEPTH, ZERO_REG, BYPASS.
  - Instantiated twice, for ports A and B.
- The top level holds the storage array, the write decode, the clear FSM and addr_err.

Test Plan:
1. Reset release, DEPTH=8 -> busy=1 for 8 cycles then 0; a read of any address returns 0x0000 with rd_valid=1 one cycle after request.
2. Write 0xBEEF to addr 3, then read A=3, B=3 next cycle -> both rd_data=0xBEEF, rd_valid=1 one cycle after the read request.
3. Same-cycle write of 0x1234 to addr 5 with read A=5 (entry holds 0x00AA) -> BYPASS=1 gives 0x1234; BYPASS=0 gives 0x00AA.
4. ZERO_REG=1: write 0xFFFF to addr 0 -> wr_ack=1; a later read of addr 0 returns 0x0000.
5. DEPTH=12: write to addr 13 -> wr_ack=0 and addr_err=1 next cycle; read addr 14 -> data 0, valid 1; clr_req -> addr_err=0 and busy for 12 cycles.
6. clr_req while the file is full of 0xA5A5, with a write attempt at cycle 2 of the clear -> wr_ack=0; after busy falls, every entry reads 0x0000; reset asserted at clear cycle 4 restarts the count (busy for 8 more cycles after release).
